// File: rtl/seg7_pkg.sv
// Shared constants and FSM state type for the 7-segment scanner.
package seg7_pkg;

   localparam int SEG7_NUM_DIGITS = 8;
   localparam logic [SEG7_NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } seg7_state_e;

endpackage : seg7_pkg

// File: rtl/seg7_lz_mask.sv
// Leading-zero mask: digit i (i>=1) is blanked when it and every digit above
// it are zero. Digit 0 always shows, so a zero value displays a single "0".
module seg7_lz_mask
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = SEG7_NUM_DIGITS
) (
   input  logic [4*NUM_DIGITS-1:0] snap,
   input  logic                    lz_suppress,
   output logic [NUM_DIGITS-1:0]   suppress
);

   assign suppress[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
         assign suppress[gi] = lz_suppress && (snap[4*NUM_DIGITS-1:4*gi] == '0);
      end
   endgenerate

endmodule : seg7_lz_mask

// File: rtl/seg7_scan.sv
// Multiplexed scanner for a common-anode 7-segment display: per-frame data
// snapshot, blanking gap before each digit, optional leading-zero suppression.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = SEG7_NUM_DIGITS,
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic                    lz_suppress,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic [3:0]              nibble,
   output logic                    blank,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    dp,
   output logic                    frame_start
);

   localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam seg7_state_e   FRAME_ENTRY = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

   seg7_state_e               state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   snap_q, snap_d;
   logic                      lz_q, lz_d;
   logic [NUM_DIGITS-1:0]     dpm_q, dpm_d;
   logic                      first_q;

   logic [3:0]                nibble_q, nibble_d;
   logic                      blank_q, blank_d;
   logic [NUM_DIGITS-1:0]     an_q, an_d;
   logic                      dp_q, dp_d;
   logic                      frame_q, frame_d;

   logic [NUM_DIGITS-1:0]     suppress;

   // The mask sees next-cycle snapshot values so the registered outputs are
   // correct on the very first cycle of a new frame.
   seg7_lz_mask #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_lz_mask (
      .snap        (snap_d),
      .lz_suppress (lz_d),
      .suppress    (suppress)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      snap_d  = snap_q;
      lz_d    = lz_q;
      dpm_d   = dpm_q;
      frame_d = 1'b0;

      if (first_q) begin
         state_d = FRAME_ENTRY;
         cnt_d   = '0;
         idx_d   = '0;
         snap_d  = data;
         lz_d    = lz_suppress;
         dpm_d   = dp_mask;
         frame_d = 1'b1;
      end else begin
         case (state_q)
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_SHOW;
                  cnt_d   = '0;
               end
            end
            ST_SHOW: begin
               if (cnt_q == DIGIT_LAST) begin
                  state_d = FRAME_ENTRY;
                  cnt_d   = '0;
                  if (idx_q == IDX_LAST) begin
                     idx_d   = '0;
                     snap_d  = data;
                     lz_d    = lz_suppress;
                     dpm_d   = dp_mask;
                     frame_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
            default: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      an_d     = ANODE_OFF;
      blank_d  = 1'b1;
      dp_d     = 1'b1;
      nibble_d = snap_d[{idx_d, 2'b00} +: 4];
      if (state_d == ST_SHOW && !suppress[idx_d]) begin
         an_d[idx_d] = 1'b0;
         blank_d     = 1'b0;
         dp_d        = ~dpm_d[idx_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_BLANK;
         cnt_q    <= '0;
         idx_q    <= '0;
         snap_q   <= '0;
         lz_q     <= 1'b0;
         dpm_q    <= '0;
         first_q  <= 1'b1;
         nibble_q <= 4'h0;
         blank_q  <= 1'b1;
         an_q     <= ANODE_OFF;
         dp_q     <= 1'b1;
         frame_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         snap_q   <= snap_d;
         lz_q     <= lz_d;
         dpm_q    <= dpm_d;
         first_q  <= 1'b0;
         nibble_q <= nibble_d;
         blank_q  <= blank_d;
         an_q     <= an_d;
         dp_q     <= dp_d;
         frame_q  <= frame_d;
      end
   end

   assign nibble      = nibble_q;
   assign blank       = blank_q;
   assign an          = an_q;
   assign dp          = dp_q;
   assign frame_start = frame_q;

endmodule : seg7_scan

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (with and without blanking gap) checked
// every cycle against a position-arithmetic model, plus literal spot checks.
module tb_seg7_scan;

   localparam int DC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data = 32'h0;
   logic        lz = 1'b0;
   logic [7:0]  dpm = 8'h0;

   logic [3:0] nib_a, nib_b;
   logic       blank_a, blank_b, dp_a, dp_b, fs_a, fs_b;
   logic [7:0] an_a, an_b;

   seg7_scan #(.NUM_DIGITS(8), .DIGIT_CYCLES(DC), .BLANK_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .data(data), .lz_suppress(lz), .dp_mask(dpm),
      .nibble(nib_a), .blank(blank_a), .an(an_a), .dp(dp_a), .frame_start(fs_a)
   );

   seg7_scan #(.NUM_DIGITS(8), .DIGIT_CYCLES(DC), .BLANK_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .data(data), .lz_suppress(lz), .dp_mask(dpm),
      .nibble(nib_b), .blank(blank_b), .an(an_b), .dp(dp_b), .frame_start(fs_b)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: t counts cycles since the first post-reset edge; each instance
   // latches its inputs whenever t lands on a multiple of its frame period.
   int          t_m = -1;
   logic [31:0] snap_a = '0, snap_b = '0;
   logic        lz_a = 1'b0, lz_b = 1'b0;
   logic [7:0]  dpm_a = '0, dpm_b = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_m <= -1;
      end else begin
         t_m <= t_m + 1;
         if ((t_m + 1) % (8 * (DC + 1)) == 0) begin
            snap_a <= data; lz_a <= lz; dpm_a <= dpm;
         end
         if ((t_m + 1) % (8 * DC) == 0) begin
            snap_b <= data; lz_b <= lz; dpm_b <= dpm;
         end
      end
   end

   typedef struct packed {
      logic [7:0] an;
      logic [3:0] nib;
      logic       chk_nib;
      logic       blank;
      logic       dp;
      logic       fs;
   } exp_t;

   function automatic exp_t expect_at(int t, int bc, logic [31:0] s, logic l, logic [7:0] m);
      exp_t e;
      int   per, pos, dig;
      logic show, sup;
      e.an = 8'hFF; e.nib = 4'h0; e.chk_nib = 1'b1; e.blank = 1'b1; e.dp = 1'b1; e.fs = 1'b0;
      if (t < 0) return e;
      per  = DC + bc;
      pos  = t % (8 * per);
      dig  = pos / per;
      show = (pos % per) >= bc;
      sup  = l && (dig >= 1) && ((s >> (4 * dig)) == 32'h0);
      e.fs      = (pos == 0);
      e.chk_nib = show;
      e.nib     = 4'((s >> (4 * dig)) & 32'hF);
      if (show && !sup) begin
         e.an    = ~(8'h01 << dig);
         e.dp    = ~m[dig];
         e.blank = 1'b0;
      end
      return e;
   endfunction

   task automatic cmp(string name, exp_t e, logic [7:0] an, logic [3:0] nib,
                      logic bl, logic d, logic fs);
      total++;
      if (an !== e.an || bl !== e.blank || d !== e.dp || fs !== e.fs ||
          (e.chk_nib && nib !== e.nib)) begin
         bad++;
         $display("FAIL %s t=%0d got an=%h nib=%h blank=%b dp=%b fs=%b want an=%h nib=%h blank=%b dp=%b fs=%b",
                  name, t_m, an, nib, bl, d, fs, e.an, e.nib, e.blank, e.dp, e.fs);
      end
   endtask

   always @(negedge clk) begin
      cmp("model_a", expect_at(t_m, 1, snap_a, lz_a, dpm_a), an_a, nib_a, blank_a, dp_a, fs_a);
      cmp("model_b", expect_at(t_m, 0, snap_b, lz_b, dpm_b), an_b, nib_b, blank_b, dp_b, fs_b);
      total++;
      if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
         bad++;
         $display("FAIL an_onehot0 got an_a=%h an_b=%h want at most one low bit", an_a, an_b);
      end
   end

   task automatic lit(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic wait_t(int target);
      int n = 0;
      while (t_m != target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (t_m != target) begin
         total++;
         bad++;
         $display("FAIL wait_t got t=%0d want t=%0d", t_m, target);
      end
   endtask

   task automatic restart(logic [31:0] d, logic l, logic [7:0] m);
      @(negedge clk);
      rst_n = 1'b0;
      data  = d; lz = l; dpm = m;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      $display("tx restart data=%h lz=%b dp_mask=%h", d, l, m);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      lit("reset_an", {24'h0, an_a}, 32'hFF);
      lit("reset_misc", {27'h0, nib_a, blank_a, dp_a, fs_a} & 32'h7F, 32'h06);

      // Scan order, gap and frame timing
      restart(32'h1234_5678, 1'b0, 8'h00);
      wait_t(0);  lit("t1_fs", {31'h0, fs_a}, 32'h1);  lit("t1_gap0", {24'h0, an_a}, 32'hFF);
                  lit("t1b_an0", {24'h0, an_b}, 32'hFE);
      wait_t(1);  lit("t1_an0", {24'h0, an_a}, 32'hFE); lit("t1_nib0", {28'h0, nib_a}, 32'h8);
      wait_t(4);  lit("t1_an0_last", {24'h0, an_a}, 32'hFE); lit("t1b_an1", {24'h0, an_b}, 32'hFD);
      wait_t(5);  lit("t1_gap1", {24'h0, an_a}, 32'hFF);
      wait_t(6);  lit("t1_an1", {24'h0, an_a}, 32'hFD); lit("t1_nib1", {28'h0, nib_a}, 32'h7);
      wait_t(36); lit("t1_an7", {24'h0, an_a}, 32'h7F); lit("t1_nib7", {28'h0, nib_a}, 32'h1);

      // Leading-zero suppression
      restart(32'h0000_00A0, 1'b1, 8'h00);
      wait_t(1);  lit("t2_d0", {23'h0, an_a, blank_a}, {23'h0, 8'hFE, 1'b0}); lit("t2_nib0", {28'h0, nib_a}, 32'h0);
      wait_t(6);  lit("t2_d1", {28'h0, nib_a}, 32'hA); lit("t2_an1", {24'h0, an_a}, 32'hFD);
      wait_t(11); lit("t2_d2", {23'h0, an_a, blank_a}, {23'h0, 8'hFF, 1'b1});
      restart(32'h0, 1'b1, 8'h00);
      wait_t(1);  lit("t2z_d0", {23'h0, an_a, blank_a}, {23'h0, 8'hFE, 1'b0});
      wait_t(6);  lit("t2z_d1", {23'h0, an_a, blank_a}, {23'h0, 8'hFF, 1'b1});

      // Mid-frame data change waits for the next frame
      restart(32'h1111_1111, 1'b0, 8'h00);
      wait_t(10); data = 32'h2222_2222;
      wait_t(31); lit("t3b_fs31", {31'h0, fs_b}, 32'h0);
      wait_t(32); lit("t3b_fs32", {31'h0, fs_b}, 32'h1); lit("t3b_nib", {28'h0, nib_b}, 32'h2);
      wait_t(36); lit("t3_old", {28'h0, nib_a}, 32'h1);
      wait_t(40); lit("t3_fs40", {31'h0, fs_a}, 32'h1);
      wait_t(41); lit("t3_new", {28'h0, nib_a}, 32'h2);

      // Decimal point
      restart(32'h1234_5678, 1'b0, 8'h04);
      wait_t(6);  lit("t4_dp_off", {31'h0, dp_a}, 32'h1);
      wait_t(11); lit("t4_dp_on", {23'h0, an_a, dp_a}, {23'h0, 8'hFB, 1'b0});
      restart(32'h0000_00A0, 1'b1, 8'h04);
      wait_t(11); lit("t4_dp_sup", {23'h0, an_a, dp_a}, {23'h0, 8'hFF, 1'b1});

      // Asynchronous reset during digit 5
      restart(32'h1234_5678, 1'b0, 8'hFF);
      wait_t(27);
      #2 rst_n = 1'b0;
      #1;
      lit("t6_async_an", {24'h0, an_a}, 32'hFF);
      lit("t6_async_misc", {28'h0, nib_a} | {27'h0, blank_a, dp_a, fs_a, 1'b0}, 32'hC);
      data = 32'hCAFE_BABE; dpm = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_t(0);  lit("t6_fs", {31'h0, fs_a}, 32'h1);
      wait_t(1);  lit("t6_an0", {24'h0, an_a}, 32'hFE); lit("t6_nib0", {28'h0, nib_a}, 32'hE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_seg7_scan
